serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: x - y - b_in, LSB first, through one
// registered full-subtractor cell with a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] x_sh_q,   x_sh_d;
  logic [WIDTH-1:0] y_sh_q,   y_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             b_out_q,  b_out_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             bit_d;
  logic             borrow_nx;
  logic [WIDTH-1:0] res_nx;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    bit_d     = x_sh_q[0] ^ y_sh_q[0] ^ borrow_q;
    borrow_nx = (~x_sh_q[0] & y_sh_q[0]) | (~(x_sh_q[0] ^ y_sh_q[0]) & borrow_q);
    res_nx    = {bit_d, res_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    x_sh_d   = x_sh_q;
    y_sh_d   = y_sh_q;
    res_sh_d = res_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;

    case (state_q)
      ST_SHIFT: begin
        x_sh_d   = x_sh_q >> 1;
        y_sh_d   = y_sh_q >> 1;
        res_sh_d = res_nx;
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_nx;
          b_out_d = borrow_nx;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new start directly so held start gives back-to-back ops.
        if (start) begin
          x_sh_d   = x;
          y_sh_d   = y;
          borrow_d = b_in;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      res_sh_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_sh_q   <= x_sh_d;
      y_sh_q   <= y_sh_d;
      res_sh_q <= res_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4): vector table, handshake
// corner sequences and randomized ops against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic int ref_diff(input int xa, input int ya, input int ba);
    return (xa - ya - ba) & ((1 << W) - 1);
  endfunction

  function automatic int ref_bout(input int xa, input int ya, input int ba);
    return (xa < ya + ba) ? 1 : 0;
  endfunction

  // Presents one operation at a negedge, scrambles inputs after acceptance,
  // and returns at the negedge where done is seen (or after a timeout).
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ba,
                        input bit hold_chk, input int hold_d, input int hold_bo,
                        output int lat, output int busy_cnt);
    x = xa; y = ya; b_in = ba; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = W'($urandom); y = W'($urandom); b_in = 1'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (hold_chk && lat == 1) begin
        check("diff_hold", int'(diff), hold_d);
        check("bout_hold", int'(b_out), hold_bo);
      end
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone, gap, prev_d, prev_bo, got_d, got_bo;
    int ex, ey, eb;

    vecs[0] = '{x: 4'd7,  y: 4'd3,  b: 1'b0, d: 4'd4,  bo: 1'b0};
    vecs[1] = '{x: 4'd3,  y: 4'd7,  b: 1'b0, d: 4'd12, bo: 1'b1};
    vecs[2] = '{x: 4'd0,  y: 4'd0,  b: 1'b1, d: 4'd15, bo: 1'b1};
    vecs[3] = '{x: 4'd8,  y: 4'd8,  b: 1'b0, d: 4'd0,  bo: 1'b0};
    vecs[4] = '{x: 4'd15, y: 4'd0,  b: 1'b1, d: 4'd14, bo: 1'b0};
    vecs[5] = '{x: 4'd0,  y: 4'd15, b: 1'b0, d: 4'd1,  bo: 1'b1};

    rst = 1'b1; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(b_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].b, 1'b0, 0, 0, lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, W);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, W);
      check($sformatf("vec%0d_busy_at_done", i), int'(busy), 0);
      check($sformatf("vec%0d_diff", i), int'(diff), int'(vecs[i].d));
      check($sformatf("vec%0d_bout", i), int'(vecs[i].bo), int'(b_out));
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
      check($sformatf("vec%0d_idle_after", i), int'(busy), 0);
    end

    // Busy protection: start pulse mid-operation must be ignored.
    x = 4'd9; y = 4'd2; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 4'd1; y = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; got_d = -1; got_bo = -1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        ndone++;
        got_d = int'(diff);
        got_bo = int'(b_out);
      end
      @(negedge clk);
    end
    check("busyprot_done_count", ndone, 1);
    check("busyprot_diff", got_d, 7);
    check("busyprot_bout", got_bo, 0);
    check("busyprot_no_second_op", int'(busy), 0);

    // Back-to-back with start held through the first done cycle.
    x = 4'd5; y = 4'd1; b_in = 1'b0; start = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_first_diff", int'(diff), 4);
    check("b2b_first_bout", int'(b_out), 0);
    check("b2b_busy_in_done", int'(busy), 0);
    x = 4'd1; y = 4'd2; b_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("b2b_reaccept_busy", int'(busy), 1);
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_done_spacing", lat, W + 1);
    check("b2b_second_diff", int'(diff), 15);
    check("b2b_second_bout", int'(b_out), 1);
    @(negedge clk);

    // Reset two cycles into (6 - 1).
    x = 4'd6; y = 4'd1; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_bout", int'(b_out), 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst_no_done", ndone, 0);
    run_op(4'd6, 4'd1, 1'b0, 1'b1, 0, 0, lat, bcnt);
    check("midrst_fresh_latency", lat, W);
    check("midrst_fresh_diff", int'(diff), 5);
    check("midrst_fresh_bout", int'(b_out), 0);
    prev_d = int'(diff);
    prev_bo = int'(b_out);

    // Randomized operations with random idle gaps (gap 0 = back-to-back from DONE).
    for (int n = 0; n < 500; n++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      ex = int'($urandom_range(0, (1 << W) - 1));
      ey = int'($urandom_range(0, (1 << W) - 1));
      eb = int'($urandom_range(0, 1));
      run_op(W'(ex), W'(ey), 1'(eb), 1'b1, prev_d, prev_bo, lat, bcnt);
      check($sformatf("rnd%0d_latency", n), lat, W);
      check($sformatf("rnd%0d_diff(%0d-%0d-%0d)", n, ex, ey, eb), int'(diff), ref_diff(ex, ey, eb));
      check($sformatf("rnd%0d_bout(%0d-%0d-%0d)", n, ex, ey, eb), int'(b_out), ref_bout(ex, ey, eb));
      prev_d = ref_diff(ex, ey, eb);
      prev_bo = ref_bout(ex, ey, eb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
